// File: rtl/max_forward_buffer.sv
// Two-bank group buffer: collects a group of elements with its running max,
// then replays the group with that max and its length attached to every beat.
module max_forward_buffer #(
   parameter int DATA_W     = 16,
   parameter int PAY_W      = 16,
   parameter int MAX_LEN    = 16,
   parameter int LEN_W      = 5,
   parameter int SIGNED_CMP = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [PAY_W-1:0]  i_payload,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [PAY_W-1:0]  o_payload,
   output logic [DATA_W-1:0] o_max,
   output logic [LEN_W-1:0]  o_len,
   output logic              o_first,
   output logic              o_last
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   logic [DATA_W-1:0] mem_data_r [2][MAX_LEN];
   logic [PAY_W-1:0]  mem_pay_r  [2][MAX_LEN];
   logic [1:0]        full_r;
   logic [DATA_W-1:0] max_r [2];
   logic [LEN_W-1:0]  len_r [2];
   logic              wr_bank_r;
   logic              rd_bank_r;
   logic [LEN_W-1:0]  wr_idx_r;
   logic [LEN_W-1:0]  rd_idx_r;
   logic [LEN_W-1:0]  cur_len_r;
   logic [DATA_W-1:0] run_max_r;

   logic              wr_fire_s;
   logic              wr_last_s;
   logic [LEN_W-1:0]  eff_len_s;
   logic [DATA_W-1:0] new_max_s;

   logic              free_s;
   logic              try_s;
   logic              src_full_s;
   logic              src_wr_s;
   logic              nxt_bank_s;
   logic [LEN_W-1:0]  nxt_idx_s;
   logic [DATA_W-1:0] sel_max_s;
   logic [LEN_W-1:0]  sel_len_s;
   logic [DATA_W-1:0] src_data_s;
   logic [PAY_W-1:0]  src_pay_s;
   logic              nxt_valid_s;
   logic              nxt_first_s;
   logic              nxt_last_s;
   logic [DATA_W-1:0] nxt_data_s;
   logic [PAY_W-1:0]  nxt_pay_s;
   logic [DATA_W-1:0] nxt_max_s;
   logic [LEN_W-1:0]  nxt_len_s;

   function automatic logic gt_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (SIGNED_CMP != 0) begin
         return $signed(a) > $signed(b);
      end else begin
         return a > b;
      end
   endfunction

   assign o_ready = ~full_r[wr_bank_r];

   // Write side: group length clamp, running max and group-close detection
   always_comb begin
      wr_fire_s = i_en & i_valid & ~full_r[wr_bank_r];
      eff_len_s = cur_len_r;
      new_max_s = run_max_r;
      if (wr_idx_r == LEN_W'(0)) begin
         if (i_len == LEN_W'(0)) begin
            eff_len_s = LEN_W'(1);
         end else if (i_len > MAX_LEN_L) begin
            eff_len_s = MAX_LEN_L;
         end else begin
            eff_len_s = i_len;
         end
         new_max_s = i_data;
      end else begin
         eff_len_s = cur_len_r;
         new_max_s = gt_f(i_data, run_max_r) ? i_data : run_max_r;
      end
      wr_last_s = (wr_idx_r == (eff_len_s - LEN_W'(1)));
   end

   // Read side: choose the next beat to present; a bank closing this cycle
   // is visible immediately so the first beat follows the last input by one cycle
   always_comb begin
      free_s      = 1'b0;
      try_s       = 1'b0;
      nxt_bank_s  = rd_bank_r;
      nxt_idx_s   = rd_idx_r;
      nxt_valid_s = o_valid;
      nxt_first_s = o_first;
      nxt_last_s  = o_last;
      nxt_data_s  = o_data;
      nxt_pay_s   = o_payload;
      nxt_max_s   = o_max;
      nxt_len_s   = o_len;
      if (o_valid && i_ready) begin
         if (o_last) begin
            free_s     = 1'b1;
            nxt_bank_s = ~rd_bank_r;
            nxt_idx_s  = LEN_W'(0);
         end else begin
            nxt_idx_s  = rd_idx_r + LEN_W'(1);
         end
         try_s = 1'b1;
      end else if (!o_valid) begin
         try_s = 1'b1;
      end else begin
         try_s = 1'b0;
      end
      src_full_s = full_r[nxt_bank_s];
      src_wr_s   = wr_fire_s & wr_last_s & (wr_bank_r == nxt_bank_s);
      sel_max_s  = src_full_s ? max_r[nxt_bank_s] : new_max_s;
      sel_len_s  = src_full_s ? len_r[nxt_bank_s] : eff_len_s;
      // entry being written this same cycle is forwarded from the inputs
      if (wr_fire_s && (wr_bank_r == nxt_bank_s) && (wr_idx_r == nxt_idx_s)) begin
         src_data_s = i_data;
         src_pay_s  = i_payload;
      end else begin
         src_data_s = mem_data_r[nxt_bank_s][nxt_idx_s[IDX_W-1:0]];
         src_pay_s  = mem_pay_r[nxt_bank_s][nxt_idx_s[IDX_W-1:0]];
      end
      if (try_s) begin
         if (src_full_s || src_wr_s) begin
            nxt_valid_s = 1'b1;
            nxt_first_s = (nxt_idx_s == LEN_W'(0));
            nxt_last_s  = (nxt_idx_s == (sel_len_s - LEN_W'(1)));
            nxt_data_s  = src_data_s;
            nxt_pay_s   = src_pay_s;
            nxt_max_s   = sel_max_s;
            nxt_len_s   = sel_len_s;
         end else begin
            nxt_valid_s = 1'b0;
            nxt_first_s = 1'b0;
            nxt_last_s  = 1'b0;
         end
      end else begin
         nxt_valid_s = o_valid;
      end
   end

   // Bank storage; contents are not reset
   always_ff @(posedge i_clk) begin
      if (wr_fire_s) begin
         mem_data_r[wr_bank_r][wr_idx_r[IDX_W-1:0]] <= i_data;
         mem_pay_r[wr_bank_r][wr_idx_r[IDX_W-1:0]]  <= i_payload;
      end
   end

   // Control state and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         full_r    <= 2'b00;
         max_r[0]  <= '0;
         max_r[1]  <= '0;
         len_r[0]  <= '0;
         len_r[1]  <= '0;
         wr_bank_r <= 1'b0;
         rd_bank_r <= 1'b0;
         wr_idx_r  <= LEN_W'(0);
         rd_idx_r  <= LEN_W'(0);
         cur_len_r <= LEN_W'(0);
         run_max_r <= '0;
         o_valid   <= 1'b0;
         o_first   <= 1'b0;
         o_last    <= 1'b0;
         o_data    <= '0;
         o_payload <= '0;
         o_max     <= '0;
         o_len     <= LEN_W'(0);
      end else if (i_en) begin
         if (wr_fire_s) begin
            run_max_r <= new_max_s;
            cur_len_r <= eff_len_s;
            if (wr_last_s) begin
               full_r[wr_bank_r] <= 1'b1;
               max_r[wr_bank_r]  <= new_max_s;
               len_r[wr_bank_r]  <= eff_len_s;
               wr_idx_r          <= LEN_W'(0);
               wr_bank_r         <= ~wr_bank_r;
            end else begin
               wr_idx_r <= wr_idx_r + LEN_W'(1);
            end
         end
         if (free_s) begin
            full_r[rd_bank_r] <= 1'b0;
         end
         rd_bank_r <= nxt_bank_s;
         rd_idx_r  <= nxt_idx_s;
         o_valid   <= nxt_valid_s;
         o_first   <= nxt_first_s;
         o_last    <= nxt_last_s;
         o_data    <= nxt_data_s;
         o_payload <= nxt_pay_s;
         o_max     <= nxt_max_s;
         o_len     <= nxt_len_s;
      end
   end

endmodule

// File: tb/tb_max_forward_buffer.sv
// Directed bench for max_forward_buffer: a signed and an unsigned instance
// share all inputs; expected beats, maxima and lengths are computed here.
module tb_max_forward_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, valid, ready;
   logic [15:0] data, pay;
   logic [4:0]  len;

   logic        s_ready, s_valid, s_first, s_last;
   logic [15:0] s_data, s_pay, s_max;
   logic [4:0]  s_len;
   logic        u_ready, u_valid, u_first, u_last;
   logic [15:0] u_data, u_pay, u_max;
   logic [4:0]  u_len;

   max_forward_buffer #(.SIGNED_CMP(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .o_ready(s_ready),
      .i_data(data), .i_payload(pay), .i_len(len), .o_valid(s_valid), .i_ready(ready),
      .o_data(s_data), .o_payload(s_pay), .o_max(s_max), .o_len(s_len),
      .o_first(s_first), .o_last(s_last));

   max_forward_buffer #(.SIGNED_CMP(0)) dut_u (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid), .o_ready(u_ready),
      .i_data(data), .i_payload(pay), .i_len(len), .o_valid(u_valid), .i_ready(ready),
      .o_data(u_data), .o_payload(u_pay), .o_max(u_max), .o_len(u_len),
      .o_first(u_first), .o_last(u_last));

   typedef struct packed {
      logic [15:0] d, p, smax, umax;
      logic [4:0]  len;
      logic        first, last;
   } beat_t;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [15:0] din [0:31];
   logic [15:0] pin [0:31];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic [15:0] p, input logic [4:0] l);
      valid = 1'b1; data = d; pay = p; len = l;
      for (int w = 0; w < 200 && !s_ready; w++) tick();
      if (!s_ready) chk("push_timeout", 32'd0, 32'd1);
      tick();
      valid = 1'b0;
   endtask

   task automatic send(input int base, input int n, input logic [4:0] l);
      for (int k = 0; k < n; k++)
         push(din[base+k], pin[base+k], (k == 0) ? l : 5'($urandom_range(0, 31)));
   endtask

   task automatic check_beat(input logic [15:0] d, input logic [15:0] p, input logic [15:0] smax,
                             input logic [15:0] umax, input logic [4:0] l, input logic f, input logic la);
      chk("valid", {31'd0, s_valid}, 32'd1);
      chk("data", {16'd0, s_data}, {16'd0, d});
      chk("payload", {16'd0, s_pay}, {16'd0, p});
      chk("max_signed", {16'd0, s_max}, {16'd0, smax});
      chk("max_unsigned", {16'd0, u_max}, {16'd0, umax});
      chk("len", {27'd0, s_len}, {27'd0, l});
      chk("first", {31'd0, s_first}, {31'd0, f});
      chk("last", {31'd0, s_last}, {31'd0, la});
   endtask

   task automatic rx(input int base, input int n, input logic [15:0] smax,
                     input logic [15:0] umax, input logic [4:0] l);
      ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         for (int w = 0; w < 200 && !s_valid; w++) tick();
         check_beat(din[base+k], pin[base+k], smax, umax, l, k == 0, k == n - 1);
         tick();
      end
      ready = 1'b0;
   endtask

   initial begin
      beat_t       exp_q[$];
      beat_t       e;
      logic [15:0] rin_d [0:127];
      logic [15:0] rin_p [0:127];
      logic [4:0]  rin_l [0:127];
      logic        rin_f [0:127];
      logic [15:0] sm, um, pv_d, pv_p, pv_m;
      logic [7:0]  pv_c;
      logic        acc, cons, stall;
      int          total, wi, cyc;

      rst = 1'b1; en = 1'b1; valid = 1'b0; ready = 1'b0;
      data = 16'd0; pay = 16'd0; len = 5'd0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_valid", {31'd0, s_valid}, 32'd0);
      chk("rst_first", {31'd0, s_first}, 32'd0);
      chk("rst_last", {31'd0, s_last}, 32'd0);
      chk("rst_data", {16'd0, s_data}, 32'd0);
      chk("rst_payload", {16'd0, s_pay}, 32'd0);
      chk("rst_max", {16'd0, s_max}, 32'd0);
      chk("rst_len", {27'd0, s_len}, 32'd0);
      chk("rst_ready", {31'd0, s_ready}, 32'd1);

      // basic group of 5 with one-cycle latency
      din[0] = 16'd3; din[1] = 16'd7; din[2] = 16'd25; din[3] = 16'd4; din[4] = 16'd1;
      for (int k = 0; k < 5; k++) pin[k] = 16'hABC0 + 16'(k);
      send(0, 4, 5'd5);
      chk("lat_before_last", {31'd0, s_valid}, 32'd0);
      push(din[4], pin[4], 5'd9);
      chk("lat_one_cycle", {31'd0, s_valid}, 32'd1);
      rx(0, 5, 16'd25, 16'd25, 5'd5);
      chk("g5_idle", {31'd0, s_valid}, 32'd0);

      // signed versus unsigned compare
      din[0] = 16'hFFF0; din[1] = 16'hFFFE; din[2] = 16'hFFF5;
      for (int k = 0; k < 3; k++) pin[k] = 16'h0010 + 16'(k);
      send(0, 3, 5'd3);
      rx(0, 3, 16'hFFFE, 16'hFFFE, 5'd3);
      din[0] = 16'h0001; din[1] = 16'hFFFF; din[2] = 16'h0002;
      send(0, 3, 5'd3);
      rx(0, 3, 16'h0002, 16'hFFFF, 5'd3);

      // length 0 becomes 1, length 20 clamps to 16
      din[0] = 16'h1234; pin[0] = 16'h0077;
      send(0, 1, 5'd0);
      chk("len0_lat", {31'd0, s_valid}, 32'd1);
      rx(0, 1, 16'h1234, 16'h1234, 5'd1);
      for (int k = 0; k < 16; k++) begin
         din[k] = 16'h0100 + 16'(k);
         pin[k] = 16'h0200 + 16'(k);
      end
      send(0, 16, 5'd20);
      chk("len20_closed", {31'd0, s_valid}, 32'd1);
      rx(0, 16, 16'h010F, 16'h010F, 5'd16);

      // three back-to-back groups of 4 under backpressure
      for (int k = 0; k < 12; k++) begin
         din[k] = 16'(10 * (k / 4 + 1) + k % 4);
         pin[k] = 16'h0040 + 16'(k);
      end
      send(0, 4, 5'd4);
      send(4, 4, 5'd4);
      chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
      chk("bp_valid", {31'd0, s_valid}, 32'd1);
      valid = 1'b1; data = din[8]; pay = pin[8]; len = 5'd4;
      tick(); tick();
      chk("bp_hold_data", {16'd0, s_data}, 32'd10);
      chk("bp_ready_still_low", {31'd0, s_ready}, 32'd0);
      ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_beat(din[k], pin[k], 16'd13, 16'd13, 5'd4, k == 0, k == 3);
         if (k == 3) chk("bp_ready_before_free", {31'd0, s_ready}, 32'd0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         check_beat(din[4+k], pin[4+k], 16'd23, 16'd23, 5'd4, k == 0, k == 3);
         if (k == 0) chk("bp_ready_after_free", {31'd0, s_ready}, 32'd1);
         valid = 1'b1; data = din[8+k]; pay = pin[8+k];
         len = (k == 0) ? 5'd4 : 5'd1;
         tick();
      end
      valid = 1'b0;
      chk("bp_no_bubble_c", {31'd0, s_valid}, 32'd1);
      rx(8, 4, 16'd33, 16'd33, 5'd4);

      // randomized throttling over 13 groups with a scoreboard
      total = 0;
      for (int g = 0; g < 13; g++) begin
         sm = 16'd0; um = 16'd0;
         for (int k = 0; k <= g; k++) begin
            rin_d[total+k] = 16'($urandom);
            rin_p[total+k] = {8'(g), 8'(k)};
            rin_f[total+k] = (k == 0);
            rin_l[total+k] = 5'(g + 1);
            if (k == 0 || $signed(rin_d[total+k]) > $signed(sm)) sm = rin_d[total+k];
            if (k == 0 || rin_d[total+k] > um) um = rin_d[total+k];
         end
         for (int k = 0; k <= g; k++) begin
            e.d = rin_d[total+k]; e.p = rin_p[total+k]; e.smax = sm; e.umax = um;
            e.len = 5'(g + 1); e.first = (k == 0); e.last = (k == g);
            exp_q.push_back(e);
         end
         total += g + 1;
      end
      wi = 0; cyc = 0; stall = 1'b0;
      pv_d = 16'd0; pv_p = 16'd0; pv_m = 16'd0; pv_c = 8'd0;
      while (exp_q.size() > 0 && cyc < 5000) begin
         en    = ($urandom_range(0, 4) != 0);
         valid = (wi < total) && ($urandom_range(0, 2) != 0);
         ready = ($urandom_range(0, 2) != 0);
         if (wi < total) begin
            data = rin_d[wi]; pay = rin_p[wi];
            len  = rin_f[wi] ? rin_l[wi] : 5'($urandom_range(0, 31));
         end
         if (stall) begin
            chk("stall_data", {16'd0, s_data}, {16'd0, pv_d});
            chk("stall_payload", {16'd0, s_pay}, {16'd0, pv_p});
            chk("stall_max", {16'd0, s_max}, {16'd0, pv_m});
            chk("stall_ctrl", {24'd0, s_valid, s_first, s_last, s_len}, {24'd0, pv_c});
         end
         acc  = en & valid & s_ready;
         cons = en & s_valid & ready;
         if (cons) begin
            e = exp_q.pop_front();
            check_beat(e.d, e.p, e.smax, e.umax, e.len, e.first, e.last);
         end
         stall = s_valid & ~cons;
         pv_d = s_data; pv_p = s_pay; pv_m = s_max;
         pv_c = {s_valid, s_first, s_last, s_len};
         tick();
         if (acc) wi++;
         cyc++;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      en = 1'b1; valid = 1'b0; ready = 1'b0;
      tick();
      chk("rand_idle", {31'd0, s_valid}, 32'd0);

      // reset mid-write, then reset mid-replay
      for (int k = 0; k < 6; k++) begin
         din[k] = 16'h0500 + 16'(k);
         pin[k] = 16'h0600 + 16'(k);
      end
      send(0, 2, 5'd6);
      valid = 1'b1; data = din[2]; pay = pin[2]; rst = 1'b1;
      tick();
      rst = 1'b0; valid = 1'b0;
      chk("rstw_valid", {31'd0, s_valid}, 32'd0);
      chk("rstw_ready", {31'd0, s_ready}, 32'd1);
      send(0, 3, 5'd3);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("rstr_second_beat", {16'd0, s_data}, {16'd0, din[1]});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstr_valid", {31'd0, s_valid}, 32'd0);
      chk("rstr_ready", {31'd0, s_ready}, 32'd1);
      chk("rstr_max", {16'd0, s_max}, 32'd0);
      chk("rstr_len", {27'd0, s_len}, 32'd0);
      din[0] = 16'd9; din[1] = 16'd4; pin[0] = 16'h0901; pin[1] = 16'h0902;
      send(0, 2, 5'd2);
      rx(0, 2, 16'd9, 16'd9, 5'd2);
      ready = 1'b1;
      tick(); tick();
      chk("rst_group_alone", {31'd0, s_valid}, 32'd0);
      chk("rst_ready_final", {31'd0, s_ready}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
